dtc_window_vote: RTL

DTC_WINDOW_VOTE -- requirements
Module: dtc_window_vote

---
 rtl/dtc_window_vote.sv | 101 ++++++++++
 1 files changed

// File: rtl/dtc_window_vote.sv
// Majority vote over a window of 3-bit classifier predictions.
// Accumulates per-class counts, scans for the winner, then holds the result until taken.
module dtc_window_vote #(
    parameter int WIN = 8,
    parameter int CW  = $clog2(WIN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    inp,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    outp,
    output logic [CW-1:0] out_count,
    output logic          busy
);

    // state | meaning
    // ACCUM | counting accepted predictions into cnt[]
    // SCAN  | sidx=0 loads best from cnt[0]; sidx=1..7 compare one class each
    // EMIT  | result held on outp/out_count until out_ready
    typedef enum logic [1:0] {ACCUM, SCAN, EMIT} state_t;

    state_t        state;
    logic [CW-1:0] cnt [8];
    logic [CW-1:0] scnt;
    logic [2:0]    sidx;
    logic [2:0]    best_idx;
    logic [CW-1:0] best_cnt;

    logic          accept;
    logic [CW-1:0] scnt_inc;
    logic [CW-1:0] cand;
    logic          take;
    logic          close_win;

    assign in_ready  = (state == ACCUM);
    assign busy      = (state != ACCUM);
    assign accept    = in_valid && in_ready;
    assign scnt_inc  = scnt + CW'(1);
    assign cand      = cnt[sidx];
    // strict compare keeps the lowest class index on ties
    assign take      = (cand > best_cnt);
    assign close_win = (accept && (scnt_inc == CW'(WIN))) || (flush && (accept || (scnt != '0)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            for (int i = 0; i < 8; i++) cnt[i] <= '0;
            scnt      <= '0;
            sidx      <= '0;
            best_idx  <= '0;
            best_cnt  <= '0;
            out_valid <= 1'b0;
            outp      <= '0;
            out_count <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        cnt[inp] <= cnt[inp] + CW'(1);
                        scnt     <= scnt_inc;
                    end
                    if (close_win) begin
                        state <= SCAN;
                        sidx  <= '0;
                    end
                end
                SCAN: begin
                    // cnt[0] is loaded one cycle after close so a same-edge increment is seen
                    if (sidx == 3'd0) begin
                        best_idx <= '0;
                        best_cnt <= cnt[0];
                    end else if (take) begin
                        best_idx <= sidx;
                        best_cnt <= cand;
                    end
                    sidx <= sidx + 3'd1;
                    if (sidx == 3'd7) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        outp      <= take ? sidx : best_idx;
                        out_count <= take ? cand : best_cnt;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        state     <= ACCUM;
                        out_valid <= 1'b0;
                        for (int i = 0; i < 8; i++) cnt[i] <= '0;
                        scnt      <= '0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
